// File: rtl/alu_share_arbiter.sv
// alu_share_arbiter
//   Shares one external combinational ALU (ADD=3'b000, CMP/BNE=3'b001) between
//   two requesters. Round-robin grant, at most one grant per cycle. The ALU
//   result is registered into a per-port response slot that is held until the
//   owning port consumes it.
//
// Ports
//   clk, rst                 clock, synchronous active-high reset
//   req_valid/req_ready[2]   request handshake (req_ready = grant)
//   req_op1/req_op2          per-port operands, port n at [n*DATA_WIDTH +: DATA_WIDTH]
//   req_ctrl                 per-port ALU control, port n at [n*3 +: 3]
//   resp_valid/resp_ready[2] response slot full / consumed this cycle
//   resp_out, resp_eq        per-port registered ALU result and EQ flag
//   alu_op1/op2/ctrl         drive to the shared ALU (idle: 0, 0, 3'b111)
//   alu_out, alu_eq          result from the shared ALU
//   stall_cnt                per-port saturating stall counters, port n at
//                            [n*CNT_WIDTH +: CNT_WIDTH]
//
// Build option
//   ALU_ARB_STALL_CNT_EN     when defined, adds stall_cnt and its counters.

module alu_share_arbiter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned CNT_WIDTH  = 16
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              req_valid,
    output logic [1:0]              req_ready,
    input  logic [2*DATA_WIDTH-1:0] req_op1,
    input  logic [2*DATA_WIDTH-1:0] req_op2,
    input  logic [5:0]              req_ctrl,
    output logic [1:0]              resp_valid,
    input  logic [1:0]              resp_ready,
    output logic [2*DATA_WIDTH-1:0] resp_out,
    output logic [1:0]              resp_eq,
    output logic [DATA_WIDTH-1:0]   alu_op1,
    output logic [DATA_WIDTH-1:0]   alu_op2,
    output logic [2:0]              alu_ctrl,
    input  logic [DATA_WIDTH-1:0]   alu_out,
    input  logic                    alu_eq
`ifdef ALU_ARB_STALL_CNT_EN
    ,
    output logic [2*CNT_WIDTH-1:0]  stall_cnt
`endif
);

    localparam logic [2:0] CTRL_IDLE = 3'b111;

    typedef enum logic {
        SLOT_EMPTY = 1'b0,
        SLOT_FULL  = 1'b1
    } slot_t;

    if (CNT_WIDTH < 1) begin : g_cnt_width_check
        $error("CNT_WIDTH must be at least 1");
    end

    slot_t                  slot_q [2];
    slot_t                  slot_d [2];
    logic [DATA_WIDTH-1:0]  data_q [2];
    logic [1:0]             eq_q;
    logic                   last_grant;
    logic [1:0]             elig;
    logic [1:0]             grant;

    // A full slot that is being drained this cycle can accept a new result.
    always_comb begin
        elig = '0;
        for (int unsigned n = 0; n < 2; n++) begin
            elig[n] = req_valid[n] && (slot_q[n] == SLOT_EMPTY || resp_ready[n]);
        end
    end

    // last_grant holds the index of the most recently granted port; a tie goes
    // to the other one.
    always_comb begin
        grant = '0;
        if (!rst) begin
            case (elig)
                2'b01:   grant = 2'b01;
                2'b10:   grant = 2'b10;
                2'b11:   grant = last_grant ? 2'b01 : 2'b10;
                default: grant = '0;
            endcase
        end
    end

    assign req_ready = grant;

    always_comb begin
        alu_op1  = '0;
        alu_op2  = '0;
        alu_ctrl = CTRL_IDLE;
        if (grant[0]) begin
            alu_op1  = req_op1[0 +: DATA_WIDTH];
            alu_op2  = req_op2[0 +: DATA_WIDTH];
            alu_ctrl = req_ctrl[0 +: 3];
        end else if (grant[1]) begin
            alu_op1  = req_op1[DATA_WIDTH +: DATA_WIDTH];
            alu_op2  = req_op2[DATA_WIDTH +: DATA_WIDTH];
            alu_ctrl = req_ctrl[3 +: 3];
        end
    end

    // Grant takes priority over drain so a same-cycle drain+refill stays FULL.
    always_comb begin
        for (int unsigned n = 0; n < 2; n++) begin
            slot_d[n] = slot_q[n];
            case (slot_q[n])
                SLOT_EMPTY: if (grant[n]) slot_d[n] = SLOT_FULL;
                SLOT_FULL: begin
                    if (grant[n])           slot_d[n] = SLOT_FULL;
                    else if (resp_ready[n]) slot_d[n] = SLOT_EMPTY;
                end
                default:    slot_d[n] = SLOT_EMPTY;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned n = 0; n < 2; n++) begin
                slot_q[n] <= SLOT_EMPTY;
                data_q[n] <= '0;
            end
            eq_q       <= '0;
            last_grant <= 1'b1;
        end else begin
            for (int unsigned n = 0; n < 2; n++) begin
                slot_q[n] <= slot_d[n];
                if (grant[n]) begin
                    data_q[n] <= alu_out;
                    eq_q[n]   <= alu_eq;
                end
            end
            if (|grant) begin
                last_grant <= grant[1];
            end
        end
    end

    always_comb begin
        resp_valid = '0;
        resp_out   = '0;
        for (int unsigned n = 0; n < 2; n++) begin
            resp_valid[n] = (slot_q[n] == SLOT_FULL);
            resp_out[n*DATA_WIDTH +: DATA_WIDTH] = data_q[n];
        end
    end

    assign resp_eq = eq_q;

`ifdef ALU_ARB_STALL_CNT_EN
    logic [CNT_WIDTH-1:0] stall_q [2];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int unsigned n = 0; n < 2; n++) begin
                stall_q[n] <= '0;
            end
        end else begin
            for (int unsigned n = 0; n < 2; n++) begin
                if (req_valid[n] && !req_ready[n] && stall_q[n] != '1) begin
                    stall_q[n] <= stall_q[n] + 1'b1;
                end
            end
        end
    end

    always_comb begin
        stall_cnt = '0;
        for (int unsigned n = 0; n < 2; n++) begin
            stall_cnt[n*CNT_WIDTH +: CNT_WIDTH] = stall_q[n];
        end
    end
`endif

endmodule
